// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified memory port arbiter: FSM state
// encodings, the last-grant marker and the arbitration decision helper.
package mem_port_arbiter_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT_I = 2'd1;
    localparam logic [1:0] ARB_GRANT_D = 2'd2;

    // Values of the `last` register (most recent grant)
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    // Choose the next grant from IDLE. A lone requester wins outright;
    // on a conflict the side that was not granted last time wins.
    function automatic logic [1:0] arb_pick(input logic istb,
                                            input logic dstb,
                                            input logic last);
        logic [1:0] pick;
        pick = ARB_IDLE;
        if (istb && dstb) begin
            pick = (last == LAST_I) ? ARB_GRANT_D : ARB_GRANT_I;
        end else if (istb) begin
            pick = ARB_GRANT_I;
        end else if (dstb) begin
            pick = ARB_GRANT_D;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Bus watchdog for the memory port arbiter. Counts grant cycles without an
// acknowledge and flags expiry once the count reaches TIMEOUT. With
// TIMEOUT=0 the watchdog is disabled and expired never rises.
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Wait counter: cleared while idle, saturates at LIMIT during a grant
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (I)
// and data access (D). Round-robin on conflicts, one transaction per grant,
// mandatory IDLE cycle between grants, and a watchdog that completes a
// stalled transaction with an error flag instead of hanging the pipeline.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            i_Istb,
    input  logic [AW-1:0]   i_Iaddr,
    output logic            o_Iack,
    output logic [DW-1:0]   o_Idata,
    output logic            o_Ierr,

    input  logic            i_Dstb,
    input  logic            i_Dwe,
    input  logic [AW-1:0]   i_Daddr,
    input  logic [DW-1:0]   i_Dwdata,
    input  logic [DW/8-1:0] i_Dsel,
    output logic            o_Dack,
    output logic [DW-1:0]   o_Ddata,
    output logic            o_Derr,

    output logic            o_mem_stb,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_sel,
    input  logic            i_mem_ack,
    input  logic [DW-1:0]   i_mem_rdata
);

    logic [1:0] state;
    logic       last;
    logic [1:0] pick;
    logic       launch;
    logic       in_grant;
    logic       xact_done;
    logic       expired;
    logic       grant_i;
    logic       grant_d;

    assign pick      = arb_pick(i_Istb, i_Dstb, last);
    assign launch    = (state == ARB_IDLE) && (pick != ARB_IDLE);
    assign in_grant  = (state == ARB_GRANT_I) || (state == ARB_GRANT_D);
    assign xact_done = in_grant && (i_mem_ack || expired);

    // Responses are suppressed while reset is asserted so an aborted
    // transaction never produces an ack, even if memory answers that cycle.
    assign grant_i = (state == ARB_GRANT_I) && !rst;
    assign grant_d = (state == ARB_GRANT_D) && !rst;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ARB_IDLE),
        .enable  (in_grant && !i_mem_ack),
        .expired (expired)
    );

    // Arbitration FSM and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            last  <= LAST_I;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick == ARB_GRANT_I) begin
                        state <= ARB_GRANT_I;
                        last  <= LAST_I;
                    end else if (pick == ARB_GRANT_D) begin
                        state <= ARB_GRANT_D;
                        last  <= LAST_D;
                    end
                end
                ARB_GRANT_I,
                ARB_GRANT_D: begin
                    if (xact_done) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Memory request registers: loaded once on grant entry, held constant
    // for the whole grant, strobe dropped on ack or watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_mem_stb   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_sel   <= '0;
        end else if (launch) begin
            o_mem_stb <= 1'b1;
            if (pick == ARB_GRANT_I) begin
                o_mem_we    <= 1'b0;
                o_mem_addr  <= i_Iaddr;
                o_mem_wdata <= '0;
                o_mem_sel   <= '1;
            end else begin
                o_mem_we    <= i_Dwe;
                o_mem_addr  <= i_Daddr;
                o_mem_wdata <= i_Dwdata;
                o_mem_sel   <= i_Dsel;
            end
        end else if (xact_done) begin
            o_mem_stb <= 1'b0;
        end
    end

    // Completion steering: a real ack wins over a simultaneous expiry;
    // the ungranted side always sees zeros.
    always_comb begin
        o_Iack  = 1'b0;
        o_Idata = '0;
        o_Ierr  = 1'b0;
        o_Dack  = 1'b0;
        o_Ddata = '0;
        o_Derr  = 1'b0;
        if (grant_i) begin
            o_Iack  = i_mem_ack || expired;
            o_Idata = i_mem_ack ? i_mem_rdata : '0;
            o_Ierr  = !i_mem_ack && expired;
        end else if (grant_d) begin
            o_Dack  = i_mem_ack || expired;
            o_Ddata = i_mem_ack ? i_mem_rdata : '0;
            o_Derr  = !i_mem_ack && expired;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): fetch timing, round-robin
// order, store field pass-through, watchdog expiry, reset abort and field
// stability under a slow memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_Istb;
    logic [31:0] i_Iaddr;
    logic        o_Iack;
    logic [31:0] o_Idata;
    logic        o_Ierr;
    logic        i_Dstb;
    logic        i_Dwe;
    logic [31:0] i_Daddr;
    logic [31:0] i_Dwdata;
    logic [3:0]  i_Dsel;
    logic        o_Dack;
    logic [31:0] o_Ddata;
    logic        o_Derr;
    logic        o_mem_stb;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_sel;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_Istb      (i_Istb),
        .i_Iaddr     (i_Iaddr),
        .o_Iack      (o_Iack),
        .o_Idata     (o_Idata),
        .o_Ierr      (o_Ierr),
        .i_Dstb      (i_Dstb),
        .i_Dwe       (i_Dwe),
        .i_Daddr     (i_Daddr),
        .i_Dwdata    (i_Dwdata),
        .i_Dsel      (i_Dsel),
        .o_Dack      (o_Dack),
        .o_Ddata     (o_Ddata),
        .o_Derr      (o_Derr),
        .o_mem_stb   (o_mem_stb),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_sel   (o_mem_sel),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One granted transaction with 1-cycle memory; the loser keeps requesting.
    task automatic xact(input logic is_d, input logic [31:0] exp_addr,
                        input logic exp_we, input string tag);
        logic [31:0] rd;
        step();
        check_val({tag, "_addr"}, 64'(o_mem_addr), 64'(exp_addr));
        check_val({tag, "_we"}, 64'(o_mem_we), 64'(exp_we));
        if (is_d) i_Istb = 1'b1; else i_Dstb = 1'b1;
        step();
        rd = exp_addr ^ 32'h5A5A_0000;
        i_mem_ack   = 1'b1;
        i_mem_rdata = rd;
        settle();
        check_val({tag, "_iack"}, 64'(o_Iack), 64'(!is_d));
        check_val({tag, "_dack"}, 64'(o_Dack), 64'(is_d));
        check_val({tag, "_data"}, is_d ? 64'(o_Ddata) : 64'(o_Idata), 64'(rd));
        step();
        i_mem_ack = 1'b0;
        if (is_d) i_Dstb = 1'b0; else i_Istb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        i_Istb = 1'b0; i_Iaddr = '0;
        i_Dstb = 1'b0; i_Dwe = 1'b0; i_Daddr = '0; i_Dwdata = '0; i_Dsel = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        step();
        step();
        check_val("rst_stb",  64'(o_mem_stb), 64'd0);
        check_val("rst_addr", 64'(o_mem_addr), 64'd0);
        check_val("rst_sel",  64'(o_mem_sel), 64'd0);
        check_val("rst_acks", 64'({o_Iack, o_Dack, o_Ierr, o_Derr}), 64'd0);
        rst = 1'b0;
        step();

        // I-only fetch, 1-cycle memory
        i_Istb = 1'b1; i_Iaddr = 32'h0000_0004;
        step();
        check_val("f_stb",  64'(o_mem_stb), 64'd1);
        check_val("f_addr", 64'(o_mem_addr), 64'h4);
        check_val("f_we",   64'(o_mem_we), 64'd0);
        check_val("f_sel",  64'(o_mem_sel), 64'hF);
        check_val("f_noack", 64'(o_Iack), 64'd0);
        step();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
        settle();
        check_val("f_iack",  64'(o_Iack), 64'd1);
        check_val("f_idata", 64'(o_Idata), 64'h1234_5678);
        check_val("f_ierr",  64'(o_Ierr), 64'd0);
        check_val("f_dack",  64'(o_Dack), 64'd0);
        step();
        i_mem_ack = 1'b0; i_Istb = 1'b0;
        settle();
        check_val("f_stb_low", 64'(o_mem_stb), 64'd0);
        check_val("f_ack_low", 64'(o_Iack), 64'd0);

        // Simultaneous requests: D first, then alternating
        i_Istb = 1'b1; i_Iaddr = 32'h40;
        i_Dstb = 1'b1; i_Dwe = 1'b0; i_Daddr = 32'h200; i_Dsel = 4'hF; i_Dwdata = '0;
        xact(1'b1, 32'h200, 1'b0, "rr1_d");
        xact(1'b0, 32'h40,  1'b0, "rr2_i");
        xact(1'b1, 32'h200, 1'b0, "rr3_d");
        xact(1'b0, 32'h40,  1'b0, "rr4_i");
        i_Dstb = 1'b0;
        step();

        // D store field pass-through
        i_Dstb = 1'b1; i_Dwe = 1'b1; i_Daddr = 32'h100;
        i_Dwdata = 32'hDEAD_BEEF; i_Dsel = 4'h3;
        step();
        check_val("st_stb",   64'(o_mem_stb), 64'd1);
        check_val("st_we",    64'(o_mem_we), 64'd1);
        check_val("st_addr",  64'(o_mem_addr), 64'h100);
        check_val("st_wdata", 64'(o_mem_wdata), 64'hDEAD_BEEF);
        check_val("st_sel",   64'(o_mem_sel), 64'h3);
        step();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0;
        settle();
        check_val("st_dack", 64'(o_Dack), 64'd1);
        check_val("st_derr", 64'(o_Derr), 64'd0);
        check_val("st_iack", 64'(o_Iack), 64'd0);
        step();
        i_mem_ack = 1'b0; i_Dstb = 1'b0; i_Dwe = 1'b0;

        // Watchdog: memory never answers a D load
        i_Dstb = 1'b1; i_Daddr = 32'h300; i_Dsel = 4'hF;
        step();
        i_Istb = 1'b1; i_Iaddr = 32'h80;
        i_mem_rdata = 32'hFFFF_FFFF;
        step();
        step();
        step();
        check_val("to_early", 64'(o_Dack), 64'd0);
        step();
        check_val("to_dack", 64'(o_Dack), 64'd1);
        check_val("to_derr", 64'(o_Derr), 64'd1);
        check_val("to_data", 64'(o_Ddata), 64'd0);
        check_val("to_iack", 64'(o_Iack), 64'd0);
        step();
        i_Dstb = 1'b0;
        check_val("to_stb_low", 64'(o_mem_stb), 64'd0);
        step();
        check_val("to_i_addr", 64'(o_mem_addr), 64'h80);
        check_val("to_i_sel",  64'(o_mem_sel), 64'hF);
        step();
        i_mem_ack = 1'b1; i_mem_rdata = 32'hAAAA_0080;
        settle();
        check_val("to_i_ack",  64'(o_Iack), 64'd1);
        check_val("to_i_err",  64'(o_Ierr), 64'd0);
        step();
        i_mem_ack = 1'b0; i_Istb = 1'b0;
        step();

        // Reset during GRANT_I, then a late ack
        i_Istb = 1'b1; i_Iaddr = 32'h44;
        step();
        check_val("ra_stb_hi", 64'(o_mem_stb), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; i_Istb = 1'b0;
        settle();
        check_val("ra_stb",  64'(o_mem_stb), 64'd0);
        check_val("ra_addr", 64'(o_mem_addr), 64'd0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_2222;
        settle();
        check_val("ra_iack",  64'(o_Iack), 64'd0);
        check_val("ra_idata", 64'(o_Idata), 64'd0);
        check_val("ra_dack",  64'(o_Dack), 64'd0);
        step();
        i_mem_ack = 1'b0;
        check_val("ra_idle", 64'(o_mem_stb), 64'd0);
        step();

        // 3-cycle memory: fields hold while the fetch address moves
        i_Istb = 1'b1; i_Iaddr = 32'h10;
        step();
        check_val("sl_addr0", 64'(o_mem_addr), 64'h10);
        i_Iaddr = 32'h999;
        step();
        check_val("sl_addr1", 64'(o_mem_addr), 64'h10);
        i_Iaddr = 32'h777;
        step();
        check_val("sl_addr2", 64'(o_mem_addr), 64'h10);
        check_val("sl_sel",   64'(o_mem_sel), 64'hF);
        check_val("sl_wdata", 64'(o_mem_wdata), 64'd0);
        step();
        i_mem_ack = 1'b1; i_mem_rdata = 32'hC0DE_0010;
        settle();
        check_val("sl_iack",  64'(o_Iack), 64'd1);
        check_val("sl_idata", 64'(o_Idata), 64'hC0DE_0010);
        check_val("sl_addr3", 64'(o_mem_addr), 64'h10);
        step();
        i_mem_ack = 1'b0; i_Istb = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
